// File: rtl/branch_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pa_pkg: shared definitions for the branch redirect sequencer.
//   - state_e : sequencer state encoding (RUN / FLUSH / REDIRECT). The fourth
//               code 2'b11 is unused and is steered back to RUN by the FSM.
//   - DIR_FWD / DIR_BWD : branch direction codes carried on br_dir_i.
// No ports (package only).
// -----------------------------------------------------------------------------
package pa_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_REDIRECT = 2'b10
    } state_e;

    localparam logic DIR_FWD = 1'b1;  // target = pc + offset
    localparam logic DIR_BWD = 1'b0;  // target = pc - offset

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl_if: bundles the branch-unit request, the fetch redirect
// handshake and the front-end status outputs of branch_redirect_ctrl.
//   slave  : the sequencer side (consumes requests, drives status/redirect)
//   master : the environment side (branch unit + fetch)
// Signals:
//   enable_i, br_valid_i, br_dir_i, br_offset_i, br_pc_i, fetch_ready_i  (to ctrl)
//   br_ack_o, flush_o, stall_o, redirect_valid_o, redirect_pc_o,
//   pc_o, pc_valid_o, taken_count_o                                      (from ctrl)
// -----------------------------------------------------------------------------
interface branch_redirect_ctrl_if #(
    parameter int PC_W = 16
);
    logic            enable_i;
    logic            br_valid_i;
    logic            br_dir_i;
    logic [PC_W-1:0] br_offset_i;
    logic [PC_W-1:0] br_pc_i;
    logic            fetch_ready_i;
    logic            br_ack_o;
    logic            flush_o;
    logic            stall_o;
    logic            redirect_valid_o;
    logic [PC_W-1:0] redirect_pc_o;
    logic [PC_W-1:0] pc_o;
    logic            pc_valid_o;
    logic [15:0]     taken_count_o;

    modport slave (
        input  enable_i, br_valid_i, br_dir_i, br_offset_i, br_pc_i, fetch_ready_i,
        output br_ack_o, flush_o, stall_o, redirect_valid_o, redirect_pc_o,
               pc_o, pc_valid_o, taken_count_o
    );

    modport master (
        output enable_i, br_valid_i, br_dir_i, br_offset_i, br_pc_i, fetch_ready_i,
        input  br_ack_o, flush_o, stall_o, redirect_valid_o, redirect_pc_o,
               pc_o, pc_valid_o, taken_count_o
    );
endinterface

// File: rtl/branch_redirect_ctrl_target_calc.sv
// -----------------------------------------------------------------------------
// branch_target_calc: combinational branch target adder/subtractor.
//   br_dir_i    in  1     DIR_FWD = add offset, DIR_BWD = subtract offset
//   br_pc_i     in  PC_W  PC of the branching instruction
//   br_offset_i in  PC_W  unsigned offset
//   target_o    out PC_W  resulting target, wraps modulo 2^PC_W (no overflow flag)
// -----------------------------------------------------------------------------
module branch_target_calc
    import pa_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            br_dir_i,
    input  logic [PC_W-1:0] br_pc_i,
    input  logic [PC_W-1:0] br_offset_i,
    output logic [PC_W-1:0] target_o
);

    always_comb begin
        if (br_dir_i == DIR_FWD) begin
            target_o = br_pc_i + br_offset_i;
        end else begin
            target_o = br_pc_i - br_offset_i;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl: owns the fetch PC. In RUN it steps the PC while
// enable_i is high; a taken-branch request latches the target, pulses
// br_ack_o, holds flush_o for FLUSH_CYCLES cycles, then presents the target
// to fetch on a valid/ready redirect handshake before returning to RUN.
//   clock_i   in  rising-edge clock
//   reset_ni  in  asynchronous active-low reset
//   bus       slave modport of branch_redirect_ctrl_if (request, redirect,
//             PC and status outputs)
// Parameters: PC_W (PC width), FLUSH_CYCLES (1..15), RESET_PC.
// Optional feature macro: BRANCH_REDIRECT_STATS_EN -- when defined, a
// saturating 16-bit taken-branch counter drives taken_count_o; otherwise the
// counter is not built and taken_count_o is 0.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl
    import pa_pkg::*;
#(
    parameter int              PC_W         = 16,
    parameter int              FLUSH_CYCLES = 3,
    parameter logic [PC_W-1:0] RESET_PC     = '0
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    branch_redirect_ctrl_if.slave bus
);

    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

    state_e          state_q, state_d;
    logic [3:0]      flush_cnt_q, flush_cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            ack_q, ack_d;
    logic            pc_valid_q, pc_valid_d;
    logic [PC_W-1:0] calc_target;

    branch_target_calc #(.PC_W(PC_W)) u_target_calc (
        .br_dir_i    (bus.br_dir_i),
        .br_pc_i     (bus.br_pc_i),
        .br_offset_i (bus.br_offset_i),
        .target_o    (calc_target)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_d        = pc_q;
        target_d    = target_q;
        ack_d       = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A branch wins over a sequential step in the same cycle.
                if (bus.br_valid_i) begin
                    target_d    = calc_target;
                    ack_d       = 1'b1;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = ST_FLUSH;
                end else if (bus.enable_i) begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (bus.fetch_ready_i) begin
                    pc_d    = target_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Registered so pc_valid_o is 0 while in reset and becomes 1 from the
        // first edge after release; afterwards it equals (state == RUN).
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            ack_q       <= 1'b0;
            pc_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            ack_q       <= ack_d;
            pc_valid_q  <= pc_valid_d;
        end
    end

    assign bus.br_ack_o         = ack_q;
    assign bus.flush_o          = (state_q == ST_FLUSH);
    assign bus.stall_o          = (state_q != ST_RUN);
    assign bus.redirect_valid_o = (state_q == ST_REDIRECT);
    assign bus.redirect_pc_o    = (state_q == ST_REDIRECT) ? target_q : '0;
    assign bus.pc_o             = pc_q;
    assign bus.pc_valid_o       = pc_valid_q;

`ifdef BRANCH_REDIRECT_STATS_EN
    logic [15:0] taken_q, taken_d;

    always_comb begin
        taken_d = taken_q;
        if ((state_q == ST_RUN) && bus.br_valid_i && (taken_q != 16'hFFFF)) begin
            taken_d = taken_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            taken_q <= 16'd0;
        end else begin
            taken_q <= taken_d;
        end
    end

    assign bus.taken_count_o = taken_q;
`else
    assign bus.taken_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl: directed + random stimulus for branch_redirect_ctrl.
// The driver keeps a transaction-level reference model (PC value, pending
// target, flush/redirect phase countdown) and pushes expected PCs and
// redirect targets into queues; an independent monitor on the falling edge
// pops and compares whenever the DUT presents pc_valid_o / redirect_valid_o.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    localparam int          PC_W = 16;
    localparam int          FC   = 3;
    localparam logic [15:0] RPC  = 16'h0100;
`ifdef BRANCH_REDIRECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

    branch_redirect_ctrl #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (FC),
        .RESET_PC     (RPC)
    ) dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_tgt;
    int          m_flush_left;
    bit          m_wait;
    bit          m_fresh;
    int          m_accepts = 0;
    int          m_taken;
    logic [15:0] exp_taken_cur;
    bit          mon_en = 1'b0;
    int          mon_acks = 0;

    logic [15:0] pc_q[$];
    logic [15:0] tgt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no expected entry, required one at %0t", name, $time);
    endtask

    function automatic logic [15:0] ref_target(input bit dir, input logic [15:0] pc,
                                               input logic [15:0] off);
        int r;
        r = dir ? (int'(pc) + int'(off)) : (int'(pc) - int'(off) + 65536);
        r = r % 65536;
        return 16'(r);
    endfunction

    task automatic model_reset();
        m_pc         = RPC;
        m_tgt        = 16'h0;
        m_flush_left = 0;
        m_wait       = 1'b0;
        m_fresh      = 1'b1;
        m_taken      = 0;
        exp_taken_cur = 16'h0;
        pc_q.delete();
        tgt_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},       bus.pc_o, RPC);
        check({tag, "_pc_valid"}, bus.pc_valid_o, 0);
        check({tag, "_stall"},    bus.stall_o, 0);
        check({tag, "_flush"},    bus.flush_o, 0);
        check({tag, "_ack"},      bus.br_ack_o, 0);
        check({tag, "_rvalid"},   bus.redirect_valid_o, 0);
        check({tag, "_rpc"},      bus.redirect_pc_o, 0);
        check({tag, "_taken"},    bus.taken_count_o, 0);
    endtask

    // One clock cycle: apply inputs (we are 2 time units after a rising edge),
    // record what this cycle should show, then advance the model.
    task automatic cyc(input bit en, input bit bv, input bit dir,
                       input logic [15:0] off, input logic [15:0] bpc, input bit rdy);
        bus.enable_i      = en;
        bus.br_valid_i    = bv;
        bus.br_dir_i      = dir;
        bus.br_offset_i   = off;
        bus.br_pc_i       = bpc;
        bus.fetch_ready_i = rdy;
        if (m_flush_left == 0 && !m_wait && !m_fresh) pc_q.push_back(m_pc);
        exp_taken_cur = STATS ? 16'(m_taken) : 16'h0;
        m_fresh = 1'b0;
        if (m_flush_left == 0 && !m_wait) begin
            if (bv) begin
                m_tgt = ref_target(dir, bpc, off);
                tgt_q.push_back(m_tgt);
                m_flush_left = FC;
                m_accepts++;
                if (m_taken < 65535) m_taken++;
                $display("branch accepted pc=%h off=%h dir=%0d target=%h", bpc, off, dir, m_tgt);
            end else if (en) begin
                m_pc = 16'((int'(m_pc) + 1) % 65536);
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_wait = 1'b1;
        end else if (rdy) begin
            m_pc   = m_tgt;
            m_wait = 1'b0;
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares on the falling edge, independent of the driver.
    initial begin
        int flush_run;
        flush_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                flush_run = 0;
                continue;
            end
            check("stall", bus.stall_o, bus.flush_o | bus.redirect_valid_o);
            if (bus.pc_valid_o) begin
                if (pc_q.size() == 0) fail_now("pc");
                else check("pc", bus.pc_o, pc_q.pop_front());
            end
            if (bus.br_ack_o) begin
                mon_acks++;
                check("ack_at_flush_start", {bus.flush_o, (flush_run == 0)}, 2'b11);
            end
            if (bus.flush_o) begin
                flush_run++;
            end else if (flush_run != 0) begin
                check("flush_len", flush_run, FC);
                check("redirect_after_flush", bus.redirect_valid_o, 1);
                flush_run = 0;
            end
            if (bus.redirect_valid_o) begin
                if (tgt_q.size() == 0) begin
                    fail_now("redirect_pc");
                end else begin
                    check("redirect_pc", bus.redirect_pc_o, tgt_q[0]);
                    if (bus.fetch_ready_i) begin
                        $display("redirect handshake target=%h", bus.redirect_pc_o);
                        void'(tgt_q.pop_front());
                    end
                end
            end else begin
                check("redirect_pc_idle", bus.redirect_pc_o, 0);
            end
            check("taken_count", bus.taken_count_o, exp_taken_cur);
        end
    end

    initial begin
        bus.enable_i      = 1'b0;
        bus.br_valid_i    = 1'b0;
        bus.br_dir_i      = 1'b0;
        bus.br_offset_i   = 16'h0;
        bus.br_pc_i       = 16'h0;
        bus.fetch_ready_i = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Sequential stepping: 4 enabled cycles from RESET_PC.
        repeat (4) cyc(1, 0, 0, 16'h0, 16'h0, 0);
        check("pc_after_4", bus.pc_o, 16'h0104);
        check("pc_valid_run", bus.pc_valid_o, 1);

        // Forward branch with enable also high; junk requests during flush.
        cyc(1, 1, 1, 16'h0005, 16'h0010, 1);
        check("ack_pulse", bus.br_ack_o, 1);
        check("pc_not_incr", bus.pc_o, 16'h0104);
        cyc(0, 1, 0, 16'h0099, 16'h0300, 1);
        check("ack_ignored_in_flush", bus.br_ack_o, 0);
        cyc(0, 1, 1, 16'h0077, 16'h0400, 1);
        cyc(0, 0, 0, 16'h0, 16'h0, 1);
        cyc(0, 0, 0, 16'h0, 16'h0, 1);
        check("pc_fwd_target", bus.pc_o, 16'h0015);
        check("pc_valid_after_redirect", bus.pc_valid_o, 1);

        // Backward wrap with fetch holding off for 6 cycles.
        cyc(0, 1, 0, 16'h0005, 16'h0003, 0);
        repeat (FC) cyc(0, 0, 0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 6; i++) begin
            check("hold_rvalid", bus.redirect_valid_o, 1);
            check("hold_rpc", bus.redirect_pc_o, 16'hFFFE);
            check("hold_stall", bus.stall_o, 1);
            cyc(0, 0, 0, 16'h0, 16'h0, 0);
        end
        cyc(0, 0, 0, 16'h0, 16'h0, 1);
        check("run_after_ready", bus.stall_o, 0);
        check("pc_bwd_target", bus.pc_o, 16'hFFFE);

        // Third branch, then asynchronous reset in the middle of its flush.
        cyc(0, 1, 1, 16'h0007, 16'h0020, 1);
        cyc(0, 0, 0, 16'h0, 16'h0, 1);
        check("flush_mid", bus.flush_o, 1);
        check("taken_after_3", bus.taken_count_o, STATS ? 16'd3 : 16'd0);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0);
        end
        repeat (FC + 4) cyc(0, 0, 0, 16'h0, 16'h0, 1);

        check("tgt_q_drained", tgt_q.size(), 0);
        check("pc_q_drained", pc_q.size(), 0);
        check("ack_count", mon_acks, m_accepts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencer that sits between the branch unit and instruction fetch. It owns the program counter, accepts taken-branch requests, runs a fixed-length pipeline flush, then hands the computed target to fetch through a valid/ready redirect handshake before normal sequential fetch resumes. It is the single point that decides when the front end is flushed, stalled or redirected.

## Interface
Parameters:
- PC_W, 16, program counter and offset width
- FLUSH_CYCLES, 3, number of cycles `flush_o` is held per accepted branch (legal range 1..15)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock_i  in  1  single clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- enable_i  in  1  front end may advance; PC increments when high in RUN
- br_valid_i  in  1  taken-branch request from the branch unit
- br_dir_i  in  1  1 = forward (add offset), 0 = backward (subtract offset)
- br_offset_i  in  PC_W  unsigned branch offset
- br_pc_i  in  PC_W  PC of the branching instruction
- fetch_ready_i  in  1  fetch accepts the redirect this cycle
- br_ack_o  out  1  one-cycle pulse: request accepted
- flush_o  out  1  kill younger pipeline stages
- stall_o  out  1  high in any state other than RUN
- redirect_valid_o  out  1  redirect target is presented
- redirect_pc_o  out  PC_W  redirect target
- pc_o  out  PC_W  current fetch PC
- pc_valid_o  out  1  `pc_o` is a valid fetch address (RUN only)
- taken_count_o  out  16  taken-branch counter (feature-gated)

## Operation
- States are RUN, FLUSH and REDIRECT. The state is held in a registered 2-bit field. Encoding 2'b11 is illegal and returns to RUN.
- RUN:
  - If `br_valid_i` is high, the request is accepted. The block latches the target, pulses `br_ack_o`, loads the flush counter with FLUSH_CYCLES and moves to FLUSH. `pc_o` is not incremented in that cycle.
  - Otherwise, if `enable_i` is high, `pc_o` <= `pc_o` + 1, modulo 2^PC_W.
- Target calculation:
  - Forward: `br_pc_i` + `br_offset_i`.
  - Backward: `br_pc_i` - `br_offset_i`.
  - Both are PC_W-bit and wrap silently; there is no overflow flag.
- FLUSH:
  - `flush_o` is high and the counter decrements each cycle.
  - When the counter reaches 1, the next state is REDIRECT.
- REDIRECT:
  - `redirect_valid_o` is high and `redirect_pc_o` holds the target stable until `fetch_ready_i` is sampled high.
  - On that cycle: `pc_o` <= target, state <= RUN.
- `br_valid_i` is ignored outside RUN. It is not queued and gets no ack; the branch unit must re-present it.
- Outputs that are not driven by the current state are 0. `pc_valid_o` = (state == RUN).

## Timing
- Reset values: state RUN, `pc_o` = RESET_PC, `redirect_pc_o` = 0, `taken_count_o` = 0, all 1-bit outputs 0.
  - Reset is asynchronous and may assert in any state; deassertion takes effect at the next rising edge.
- Request sampled at edge N:
  - `br_ack_o` is high during cycle N+1.
  - `flush_o` is high for cycles N+1 .. N+FLUSH_CYCLES.
  - `redirect_valid_o` rises at N+FLUSH_CYCLES+1.
- If `fetch_ready_i` is already high at that point, the new `pc_o` and `pc_valid_o` appear at cycle N+FLUSH_CYCLES+2. Minimum branch penalty is FLUSH_CYCLES+2 cycles.
- `br_valid_i` and `enable_i` high together in RUN: the branch wins.
- `fetch_ready_i` outside REDIRECT has no effect.

## Configuration
- Macro: BRANCH_REDIRECT_STATS_EN.
- Defined: `taken_count_o` increments by 1 on every accepted request and saturates at 16'hFFFF.
- Undefined: the counter register is not built and `taken_count_o` is tied to 0.

## Structure
- The shared package `pa_pkg` holds:
  - the state enum/localparams (RUN=2'b00, FLUSH=2'b01, REDIRECT=2'b10);
  - the branch direction constants (FWD=1, BWD=0).
- One sub-module, `branch_target_calc`: a combinational PC_W-bit add/subtract selected by `br_dir_i`. The FSM, counters and PC register live in the top block.

## Test plan
- Reset with RESET_PC=0x0100, then `enable_i`=1 for 4 cycles with no branch -> `pc_o` steps 0x0101..0x0104 and `pc_valid_o`=1.
- `br_pc_i`=0x0010, `br_offset_i`=0x0005, `br_dir_i`=1, `fetch_ready_i`=1 -> `br_ack_o` 1 cycle; `flush_o` exactly 3 cycles; then `redirect_pc_o`=0x0015; `pc_o`=0x0015 at request+5.
- Backward wrap: `br_pc_i`=0x0003, offset 0x0005, dir 0 -> target 0xFFFE.
- Hold `fetch_ready_i`=0 for 6 cycles in REDIRECT -> `redirect_valid_o` and `redirect_pc_o` stay stable, `stall_o`=1, then one cycle after ready the block is in RUN.
- `br_valid_i` pulsed during FLUSH -> no ack, target unchanged. Simultaneous `br_valid_i` + `enable_i` in RUN -> `pc_o` not incremented.
- Assert `reset_ni` low mid-FLUSH -> all outputs return to reset values immediately. With BRANCH_REDIRECT_STATS_EN defined, 3 accepted branches give `taken_count_o`=3.
